bank_group_burst_seq: RTL and testbench

Per-bank-group burst sequencer sitting below the bank-group arbiter: one instance per bank group (A–D). While the arbiter holds `start`, it drains requests from the group's bank queues round-robin into the command path. It ends the session with a one-cycle `done` when the burst quota is used, the group runs empty or the command path stalls too long. It also supplies the group's `req` line back to the arbiter.

---
 rtl/bank_group_burst_seq_pkg.sv | 6 +
 rtl/bank_group_burst_seq_if.sv | 17 +
 rtl/bank_group_burst_seq_rr_bank_picker.sv | 25 ++
 rtl/bank_group_burst_seq.sv | 75 +++++++
 tb/tb_bank_group_burst_seq.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/bank_group_burst_seq_pkg.sv
// arbiter_pkg: shared state type and default limits for the bank-group arbiter and burst sequencer
package arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} burst_seq_state_e;
  localparam int DEF_MAX_BURSTS = 8;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/bank_group_burst_seq_if.sv
// bank_group_burst_seq_if: arbiter/command-path side signals of one bank-group burst sequencer
interface bank_group_burst_seq_if #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int CNT_W = $clog2(arbiter_pkg::DEF_MAX_BURSTS + 1)
);
  logic start;
  logic [NUM_BANKS-1:0] bank_valid;
  logic cmd_ready;
  logic [NUM_BANKS-1:0] bank_pop;
  logic [BANK_W-1:0] bank_sel;
  logic req;
  logic done;
  logic [CNT_W-1:0] burst_cnt;
  modport master (output start, bank_valid, cmd_ready, input bank_pop, bank_sel, req, done, burst_cnt);
  modport slave (input start, bank_valid, cmd_ready, output bank_pop, bank_sel, req, done, burst_cnt);
endinterface

// File: rtl/bank_group_burst_seq_rr_bank_picker.sv
// rr_bank_picker: combinational find-first set bit of valid, searching upward from ptr with wrap
module rr_bank_picker #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic [NUM_BANKS-1:0] valid,
  input  logic [BANK_W-1:0]    ptr,
  output logic                 grant_vld,
  output logic [BANK_W-1:0]    grant_idx
);
  logic [BANK_W-1:0] w_j;
  // Scan farthest-first so the nearest set bit from ptr is the last one written.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    w_j = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      w_j = BANK_W'((int'(ptr) + i) % NUM_BANKS);
      if (valid[w_j]) begin
        grant_vld = 1'b1;
        grant_idx = w_j;
      end
    end
  end
endmodule

// File: rtl/bank_group_burst_seq.sv
// bank_group_burst_seq: drains one bank group's queues round-robin while granted,
// ending the session on quota, empty group or command-path stall timeout.
module bank_group_burst_seq
  import arbiter_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int MAX_BURSTS = DEF_MAX_BURSTS,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int CNT_W = $clog2(MAX_BURSTS + 1)
) (
  input logic clk,
  input logic rst,
  bank_group_burst_seq_if.slave bus
);
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  burst_seq_state_e r_state;
  logic [BANK_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [STALL_W-1:0] r_stall;
  logic w_gvld;
  logic [BANK_W-1:0] w_gidx;
  logic w_issue;
  logic w_fire;
  logic w_stall;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [STALL_W-1:0] w_stall_nxt;
  logic [BANK_W-1:0] w_ptr_nxt;
  rr_bank_picker #(.NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)) u_pick (
    .valid(bus.bank_valid),
    .ptr(r_rr_ptr),
    .grant_vld(w_gvld),
    .grant_idx(w_gidx)
  );
  assign w_issue = (r_state == ST_ISSUE);
  assign w_fire = w_issue & w_gvld & bus.cmd_ready;
  assign w_stall = w_issue & w_gvld & ~bus.cmd_ready;
  assign w_cnt_nxt = r_cnt + CNT_W'(w_fire);
  assign w_stall_nxt = w_fire ? '0 : r_stall + STALL_W'(w_stall);
  assign w_ptr_nxt = (w_gidx == BANK_W'(NUM_BANKS - 1)) ? '0 : w_gidx + 1'b1;
  assign bus.bank_pop = w_fire ? NUM_BANKS'(1) << w_gidx : '0;
  assign bus.bank_sel = w_fire ? w_gidx : '0;
  assign bus.req = |bus.bank_valid;
  assign bus.done = (r_state == ST_DONE);
  assign bus.burst_cnt = r_cnt;
  // Exit checks use this cycle's next counts so a quota/timeout hit ends the session one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rr_ptr <= '0;
      r_cnt <= '0;
      r_stall <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_ISSUE;
            r_cnt <= '0;
            r_stall <= '0;
          end
        end
        ST_ISSUE: begin
          r_cnt <= w_cnt_nxt;
          r_stall <= w_stall_nxt;
          if (w_fire) r_rr_ptr <= w_ptr_nxt;
          r_state <= !bus.start                          ? ST_IDLE :
                     (w_cnt_nxt == CNT_W'(MAX_BURSTS))   ? ST_DONE :
                     (bus.bank_valid == '0)              ? ST_DONE :
                     (w_stall_nxt == STALL_W'(TIMEOUT))  ? ST_DONE : ST_ISSUE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bank_group_burst_seq.sv
// tb_bank_group_burst_seq: directed + random stimulus, session-level reference model and cycle scoreboard
module tb_bank_group_burst_seq;
  localparam int NB = 4;
  localparam int MAXB = 8;
  localparam int TO = 16;
  typedef struct {
    int cyc;
    logic [3:0] pop;
    logic [1:0] sel;
    logic done;
    logic [3:0] cnt;
    logic req;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  exp_t q[$];
  // reference model: session phase 0=idle 1=issuing 2=ending
  int m_phase = 0;
  int m_cnt = 0;
  int m_stall = 0;
  int m_ptr = 0;
  bank_group_burst_seq_if #(.NUM_BANKS(NB), .CNT_W(4)) bus ();
  bank_group_burst_seq #(.NUM_BANKS(NB), .MAX_BURSTS(MAXB), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic model_step();
    exp_t e;
    int g;
    bit fire;
    int cn;
    int sn;
    g = -1;
    for (int k = NB - 1; k >= 0; k--)
      if (bus.bank_valid[(m_ptr + k) % NB]) g = (m_ptr + k) % NB;
    fire = (m_phase == 1) && (g >= 0) && bus.cmd_ready;
    e.cyc = cyc;
    e.pop = fire ? 4'(1 << g) : 4'd0;
    e.sel = fire ? 2'(g) : 2'd0;
    e.done = (m_phase == 2);
    e.cnt = 4'(m_cnt);
    e.req = (bus.bank_valid != 0);
    q.push_back(e);
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_stall = 0; m_ptr = 0;
    end else if (m_phase == 0) begin
      if (bus.start) begin m_phase = 1; m_cnt = 0; m_stall = 0; end
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else begin
      cn = m_cnt + (fire ? 1 : 0);
      sn = fire ? 0 : m_stall + ((g >= 0 && !bus.cmd_ready) ? 1 : 0);
      if (fire) m_ptr = (g + 1) % NB;
      m_cnt = cn;
      m_stall = sn;
      if (!bus.start) m_phase = 0;
      else if (cn == MAXB || bus.bank_valid == 0 || sn == TO) m_phase = 2;
    end
  endtask
  task automatic cyc_drive(input logic r, input logic s, input logic [3:0] v, input logic c);
    rst = r;
    bus.start = s;
    bus.bank_valid = v;
    bus.cmd_ready = c;
    model_step();
    @(posedge clk);
    #2;
    cyc++;
  endtask
  task automatic chk(input string n, input int c, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", n, c, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("bank_pop", e.cyc, int'(bus.bank_pop), int'(e.pop));
      if (e.pop != 0) chk("bank_sel", e.cyc, int'(bus.bank_sel), int'(e.sel));
      chk("done", e.cyc, int'(bus.done), int'(e.done));
      chk("burst_cnt", e.cyc, int'(bus.burst_cnt), int'(e.cnt));
      chk("req", e.cyc, int'(bus.req), int'(e.req));
    end
  end
  initial begin
    logic s;
    logic [3:0] v;
    logic c;
    int stall_mode;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.bank_valid = 4'b1111;
    bus.cmd_ready = 1'b0;
    @(posedge clk);
    #2;
    cyc_drive(1, 0, 4'b1111, 0);
    // quota: 8 pops 0..3,0..3, done, idle, then next session from bank 0
    for (int i = 0; i < 16; i++) cyc_drive(0, 1, 4'b1111, 1);
    cyc_drive(0, 0, 4'b1111, 1);
    cyc_drive(0, 0, 4'b0000, 1);
    // move pointer to 3 by popping bank 2, then sparse wrap 0,2,0 and empty-out
    cyc_drive(0, 1, 4'b0100, 1);
    cyc_drive(0, 1, 4'b0100, 1);
    cyc_drive(0, 0, 4'b0100, 1);
    cyc_drive(0, 0, 4'b0000, 1);
    cyc_drive(0, 1, 4'b0101, 1);
    for (int i = 0; i < 3; i++) cyc_drive(0, 1, 4'b0101, 1);
    for (int i = 0; i < 3; i++) cyc_drive(0, 1, 4'b0000, 1);
    cyc_drive(0, 0, 4'b0000, 0);
    // timeout after 16 stalls
    for (int i = 0; i < 20; i++) cyc_drive(0, 1, 4'b0010, 0);
    cyc_drive(0, 0, 4'b0010, 0);
    // one ready cycle at stall 10 restarts the stall count
    cyc_drive(0, 1, 4'b0010, 0);
    for (int i = 0; i < 10; i++) cyc_drive(0, 1, 4'b0010, 0);
    cyc_drive(0, 1, 4'b0010, 1);
    for (int i = 0; i < 20; i++) cyc_drive(0, 1, 4'b0010, 0);
    cyc_drive(0, 0, 4'b0010, 0);
    // abort: start falls with the 3rd pop
    for (int i = 0; i < 3; i++) cyc_drive(0, 1, 4'b1111, 1);
    cyc_drive(0, 0, 4'b1111, 1);
    for (int i = 0; i < 3; i++) cyc_drive(0, 0, 4'b1111, 1);
    // empty sessions repeat while start held; then reset mid-session
    for (int i = 0; i < 9; i++) cyc_drive(0, 1, 4'b0000, 1);
    for (int i = 0; i < 3; i++) cyc_drive(0, 1, 4'b1011, 1);
    cyc_drive(1, 1, 4'b1011, 1);
    cyc_drive(0, 0, 4'b1011, 1);
    s = 1'b0;
    stall_mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) s = ~s;
      if ($urandom_range(0, 49) == 0) stall_mode = ~stall_mode;
      v = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
      c = stall_mode != 0 ? ($urandom_range(0, 30) == 0) : ($urandom_range(0, 3) != 0);
      cyc_drive($urandom_range(0, 299) == 0, s, v, c);
    end
    @(negedge clk);
    #1;
    chk("queue_drained", cyc, q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
